// File: rtl/keypad_entry.sv
`default_nettype none
// ----------------------------------------------------------------------------
// keypad_entry: 4x4 hex keypad scanner, debouncer and 8-digit entry buffer.
// Rev 1.0
// ----------------------------------------------------------------------------
module keypad_entry #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        clr,
    output logic [3:0]  col,
    input  logic [3:0]  row,
    output logic [31:0] value,
    output logic [3:0]  digit_count,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        entry_valid,
    output logic [31:0] entry_value
);
    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int DCNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [DCNT_W-1:0] DCNT_DONE = DCNT_W'(DEBOUNCE_SCANS);
    // Key codes indexed by {column, row}, row 0 being the top row.
    localparam logic [63:0] KEYMAP = 64'hDCBA_E963_F852_0741;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CNT = 2'd1,
        HELD      = 2'd2,
        REL_CNT   = 2'd3
    } state_t;

    logic [3:0]        row_meta_q, row_sync_q;
    logic [SLOT_W-1:0] slot_q;
    logic [1:0]        col_idx_q;
    logic [1:0]        hits_q;
    logic [3:0]        hit_code_q;
    state_t            state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [3:0]        cand_q, cand_d;
    logic              accept_d;
    logic [31:0]       value_q, entry_value_q;
    logic [3:0]        count_q, key_code_q;
    logic              key_valid_q, entry_valid_q;

    logic [3:0] low_rows;
    logic [2:0] low_cnt;
    logic [1:0] row_idx;
    logic [2:0] hits_sum;
    logic [1:0] hits_d;
    logic [3:0] hit_code_d;
    logic       slot_end, scan_done, scan_hit;

    // Low-row tally for the scan so far including this column; saturates at 2.
    always_comb begin
        low_rows = ~row_sync_q;
        low_cnt  = {2'b00, low_rows[0]} + {2'b00, low_rows[1]}
                 + {2'b00, low_rows[2]} + {2'b00, low_rows[3]};
        case (low_rows)
            4'b0010: row_idx = 2'd1;
            4'b0100: row_idx = 2'd2;
            4'b1000: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
        hits_sum   = {1'b0, hits_q} + low_cnt;
        hits_d     = (hits_sum > 3'd1) ? 2'd2 : hits_sum[1:0];
        hit_code_d = (low_cnt == 3'd1) ? KEYMAP[{col_idx_q, row_idx, 2'b00} +: 4] : hit_code_q;
        slot_end   = (slot_q == SLOT_LAST);
        scan_done  = slot_end && (col_idx_q == 2'd3);
        scan_hit   = (hits_d == 2'd1);
    end

    always_comb begin
        state_d  = state_q;
        dcnt_d   = dcnt_q;
        cand_d   = cand_q;
        accept_d = 1'b0;
        if (scan_done) begin
            case (state_q)
                IDLE: begin
                    if (scan_hit) begin
                        state_d = PRESS_CNT;
                        dcnt_d  = DCNT_W'(1);
                        cand_d  = hit_code_d;
                    end
                end
                PRESS_CNT: begin
                    if (!scan_hit) begin
                        state_d = IDLE;
                        dcnt_d  = '0;
                    end else if (hit_code_d == cand_q) begin
                        dcnt_d = dcnt_q + DCNT_W'(1);
                    end else begin
                        cand_d = hit_code_d;
                        dcnt_d = DCNT_W'(1);
                    end
                end
                HELD: begin
                    if (!scan_hit) begin
                        state_d = REL_CNT;
                        dcnt_d  = DCNT_W'(1);
                    end
                end
                REL_CNT: begin
                    if (scan_hit) begin
                        state_d = HELD;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q + DCNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
            if (state_d == PRESS_CNT && dcnt_d == DCNT_DONE) begin
                accept_d = 1'b1;
                state_d  = HELD;
                dcnt_d   = '0;
            end else if (state_d == REL_CNT && dcnt_d == DCNT_DONE) begin
                state_d = IDLE;
                dcnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            row_meta_q    <= 4'hF;
            row_sync_q    <= 4'hF;
            slot_q        <= '0;
            col_idx_q     <= 2'd0;
            hits_q        <= 2'd0;
            hit_code_q    <= 4'd0;
            state_q       <= IDLE;
            dcnt_q        <= '0;
            cand_q        <= 4'd0;
            value_q       <= 32'd0;
            count_q       <= 4'd0;
            key_code_q    <= 4'd0;
            key_valid_q   <= 1'b0;
            entry_valid_q <= 1'b0;
            entry_value_q <= 32'd0;
        end else begin
            row_meta_q    <= row;
            row_sync_q    <= row_meta_q;
            key_valid_q   <= 1'b0;
            entry_valid_q <= 1'b0;
            if (slot_end) begin
                slot_q     <= '0;
                col_idx_q  <= col_idx_q + 2'd1;
                hits_q     <= scan_done ? 2'd0 : hits_d;
                hit_code_q <= scan_done ? 4'd0 : hit_code_d;
            end else begin
                slot_q <= slot_q + SLOT_W'(1);
            end
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            cand_q  <= cand_d;
            if (accept_d) begin
                key_valid_q <= 1'b1;
                key_code_q  <= cand_d;
                if (cand_d <= 4'd9) begin
                    // Digits beyond the eighth are dropped silently.
                    if (count_q < 4'd8) begin
                        value_q <= {value_q[27:0], cand_d};
                        count_q <= count_q + 4'd1;
                    end
                end else begin
                    case (cand_d)
                        4'hC: begin
                            value_q <= 32'd0;
                            count_q <= 4'd0;
                        end
                        4'hD: begin
                            if (count_q != 4'd0) begin
                                value_q <= {4'h0, value_q[31:4]};
                                count_q <= count_q - 4'd1;
                            end
                        end
                        4'hE: begin
                            entry_value_q <= value_q;
                            entry_valid_q <= 1'b1;
                            value_q       <= 32'd0;
                            count_q       <= 4'd0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign col         = ~(4'b0001 << col_idx_q);
    assign value       = value_q;
    assign digit_count = count_q;
    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign entry_valid = entry_valid_q;
    assign entry_value = entry_value_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// tb_keypad_entry: keypad matrix model driving keypad_entry, with a scan-level
// reference of debounce and buffer behaviour compared on every cycle.
module tb_keypad_entry;
    localparam int SD   = 4;
    localparam int DB   = 2;
    localparam int SCAN = 4 * SD;
    // Key at index col*4+row.
    localparam logic [3:0] KM [16] = '{4'h1, 4'h4, 4'h7, 4'h0,
                                       4'h2, 4'h5, 4'h8, 4'hF,
                                       4'h3, 4'h6, 4'h9, 4'hE,
                                       4'hA, 4'hB, 4'hC, 4'hD};

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [3:0]  col, row, digit_count, key_code;
    logic [31:0] value, entry_value;
    logic        key_valid, entry_valid;
    logic [15:0] pressed = 16'h0;
    bit          chk_en = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int kv_seen = 0;
    int ev_seen = 0;

    keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk(clk), .clr(clr), .col(col), .row(row),
        .value(value), .digit_count(digit_count),
        .key_valid(key_valid), .key_code(key_code),
        .entry_valid(entry_valid), .entry_value(entry_value)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            if (col[c] == 1'b0)
                for (int r = 0; r < 4; r++)
                    if (pressed[c*4+r]) row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: scan results form a history; a key is accepted when armed and
    // the last DB results are that key; DB consecutive NONE results re-arm.
    int          m_phase;
    logic [3:0]  m_col;
    logic [31:0] m_value, m_entry;
    int          m_count;
    logic [3:0]  m_code;
    logic        m_kv, m_ev;
    int          hist [DB];
    bit          armed;
    int          res;
    bit          same;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_phase = 0; m_value = 0; m_entry = 0; m_count = 0;
            m_code = 0; m_kv = 0; m_ev = 0; armed = 1;
            for (int i = 0; i < DB; i++) hist[i] = -1;
        end else begin
            m_kv = 0;
            m_ev = 0;
            if (m_phase == SCAN - 1) begin
                res = -1;
                if ($countones(pressed) == 1)
                    for (int i = 0; i < 16; i++) if (pressed[i]) res = int'(KM[i]);
                for (int i = 0; i < DB - 1; i++) hist[i] = hist[i+1];
                hist[DB-1] = res;
                same = 1;
                for (int i = 0; i < DB; i++) if (hist[i] != res) same = 0;
                if (armed && same && res >= 0) begin
                    armed  = 0;
                    m_kv   = 1;
                    m_code = res[3:0];
                    if (res <= 9) begin
                        if (m_count < 8) begin
                            m_value = m_value * 16 + res;
                            m_count++;
                        end
                    end else if (res == 12) begin
                        m_value = 0; m_count = 0;
                    end else if (res == 13) begin
                        if (m_count > 0) begin
                            m_value = m_value / 16;
                            m_count--;
                        end
                    end else if (res == 14) begin
                        m_entry = m_value; m_ev = 1; m_value = 0; m_count = 0;
                    end
                end else if (same && res < 0) begin
                    armed = 1;
                end
            end
            m_phase = (m_phase + 1) % SCAN;
        end
        m_col = 4'hF;
        m_col[m_phase / SD] = 1'b0;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("col", col, m_col);
            check("value", value, m_value);
            check("digit_count", digit_count, m_count);
            check("key_valid", key_valid, m_kv);
            check("key_code", key_code, m_code);
            check("entry_valid", entry_valid, m_ev);
            check("entry_value", entry_value, m_entry);
            if (key_valid === 1'b1) kv_seen++;
            if (entry_valid === 1'b1) ev_seen++;
        end
    end

    function automatic logic [15:0] key_mask(input logic [3:0] k);
        for (int i = 0; i < 16; i++) if (KM[i] == k) return 16'(1) << i;
        return 16'h0;
    endfunction

    // Called at a scan boundary (+1 time unit); returns at the next boundary.
    task automatic hold(input logic [15:0] m, input int scans);
        pressed = m;
        repeat (scans * SCAN) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        hold(key_mask(k), 3);
        hold(16'h0, 3);
    endtask

    int kv0, ev0;

    initial begin
        #2 clr = 1'b1;
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        chk_en = 1'b1;
        check("rst_col", col, 4'b1110);
        check("rst_value", value, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_entry_value", entry_value, 0);

        repeat (SD) @(posedge clk); #1 check("col_step1", col, 4'b1101);
        repeat (SD) @(posedge clk); #1 check("col_step2", col, 4'b1011);
        repeat (SD) @(posedge clk); #1 check("col_step3", col, 4'b0111);
        repeat (SD) @(posedge clk); #1 check("col_step4", col, 4'b1110);

        kv0 = kv_seen;
        press(4'h1); press(4'h2); press(4'h3);
        check("digit_pulses", kv_seen - kv0, 3);
        check("digit_value", value, 32'h0000_0123);
        check("digit_count3", digit_count, 3);

        press(4'hC);
        for (int d = 1; d <= 9; d++) press(4'(d));
        check("overflow_value", value, 32'h1234_5678);
        check("overflow_count", digit_count, 8);
        press(4'hD);
        check("backspace_value", value, 32'h0123_4567);
        check("backspace_count", digit_count, 7);

        press(4'hC); press(4'h4); press(4'h2);
        ev0 = ev_seen;
        press(4'hE);
        check("enter_pulses", ev_seen - ev0, 1);
        check("enter_entry", entry_value, 32'h42);
        check("enter_value", value, 0);
        press(4'hE);
        check("empty_enter_entry", entry_value, 0);
        check("empty_enter_pulses", ev_seen - ev0, 2);
        kv0 = kv_seen;
        press(4'hC);
        check("clear_empty_pulse", kv_seen - kv0, 1);
        check("clear_empty_value", value, 0);

        kv0 = kv_seen;
        hold(key_mask(4'h5), 1); hold(16'h0, 3);
        check("bounce_no_pulse", kv_seen - kv0, 0);
        hold(key_mask(4'h1) | key_mask(4'h2), 3); hold(16'h0, 3);
        check("ghost_no_pulse", kv_seen - kv0, 0);
        hold(key_mask(4'h6), 20); hold(16'h0, 3);
        check("long_hold_pulse", kv_seen - kv0, 1);

        press(4'hC);
        hold(key_mask(4'h7), 3);
        repeat (5) @(posedge clk);
        #3 clr = 1'b1;
        #1;
        check("midscan_rst_col", col, 4'b1110);
        check("midscan_rst_value", value, 0);
        check("midscan_rst_kv", key_valid, 0);
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        kv0 = kv_seen;
        hold(key_mask(4'h7), 4);
        check("held_rst_pulse", kv_seen - kv0, 1);
        check("held_rst_value", value, 32'h7);
        hold(16'h0, 3);

        for (int it = 0; it < 60; it++) begin
            int sel;
            int a, b;
            logic [15:0] m;
            sel = $urandom_range(0, 9);
            a = $urandom_range(0, 15);
            b = (a + $urandom_range(1, 15)) % 16;
            if (sel < 2)      m = 16'h0;
            else if (sel < 4) m = (16'(1) << a) | (16'(1) << b);
            else              m = 16'(1) << a;
            hold(m, $urandom_range(1, 4));
        end
        hold(16'h0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/keypad_entry.md
# keypad_entry

Input-side counterpart of the multiplexed 7-segment display driver. It scans a 4x4 hex matrix keypad (PmodKYPD) by driving columns one at a time and sampling the rows. It debounces the result and assembles key presses into a 32-bit, 8-nibble entry buffer. The buffer `value` drives the display's 32-bit digit input directly. A completed entry is handed to the ATM control logic as a one-cycle pulse.

## Interface
- `SCAN_DIV`, 100000: clock cycles each column is driven (1 ms at 100 MHz); minimum 4.
- `DEBOUNCE_SCANS`, 4: consecutive identical full-scan results needed to accept a press or a release; minimum 1.
- `clk`  in  1  system clock.
- `clr`  in  1  asynchronous, active-high reset.
- `col`  out  4  column drive, active-low, exactly one bit low at all times.
- `row`  in  4  row sense, active-low (pulled up externally), asynchronous.
- `value`  out  32  entry buffer; most recent digit in `[3:0]`.
- `digit_count`  out  4  number of digits in the buffer, 0..8.
- `key_valid`  out  1  one-cycle pulse per accepted press.
- `key_code`  out  4  code of the last accepted key; held between pulses.
- `entry_valid`  out  1  one-cycle pulse when Enter is accepted.
- `entry_value`  out  32  buffer snapshot taken at Enter; held until the next Enter.

## Operation
- **Key map** (col c, row r; r0 is the top row):
  - c0: 1, 4, 7, 0
  - c1: 2, 5, 8, F
  - c2: 3, 6, 9, E
  - c3: A, B, C, D
- **Row synchronizer**: `row` passes through a 2-flop synchronizer before any use.
- **Column scan**:
  - Slot counter 0..SCAN_DIV-1; column index 0..3 wraps.
  - `col` = ~(1 << index).
  - Synchronized rows are sampled on the last cycle of each slot.
- **Per-scan result**, evaluated at the end of the column-3 slot:
  - Exactly one row low across all four columns: that key.
  - Anything else (no key, two or more keys): NONE.
- **Debounce FSM**:
  - IDLE: a key result goes to PRESS_CNT with count=1; NONE stays.
  - PRESS_CNT: a matching result increments count; a different key restarts count=1 with the new key; NONE returns to IDLE. When count reaches DEBOUNCE_SCANS, accept the key and go to HELD.
  - HELD: any key result, including a different key, holds. NONE goes to REL_CNT with count=1.
  - REL_CNT: NONE increments count; any key returns to HELD. When count reaches DEBOUNCE_SCANS, go to IDLE.
  - There is no autorepeat. Exactly one accept per physical press.
- **On accept**: `key_valid`=1 for one cycle and `key_code` is updated. The buffer action depends on the key:
  - Digit 0–9 with `digit_count`<8: `value` <= {value[27:0], key}; count+1. At count=8 the digit is dropped (`key_valid` still pulses).
  - C: `value`=0, count=0.
  - D (backspace): if count>0, `value` <= value>>4 and count−1; else no change.
  - E (enter): `entry_value` <= value; `entry_valid`=1; `value`=0; count=0. Enter with count=0 still pulses, with `entry_value`=0.
  - A, B, F: no buffer change.

## Timing
- **Reset values**:
  - `col`=4'b1110, `value`=0, `digit_count`=0.
  - `key_valid`=0, `key_code`=0, `entry_valid`=0, `entry_value`=0.
  - Slot counter=0, column index=0, FSM=IDLE, debounce count=0, synchronizer flops=4'b1111.
- **Scan period**: one full scan is 4·SCAN_DIV cycles. `col` changes on the cycle after the slot's last cycle.
- **Accept latency**: pulses assert on the cycle after the end-of-scan evaluation that completes debounce. `value`, `digit_count`, `key_code` and `entry_value` update on that same edge.
- **Minimum press-to-pulse**: DEBOUNCE_SCANS full scans plus synchronizer latency.
- **Reset mid-operation**: `clr` asserted at any time forces all reset values immediately (asynchronous). A key held through reset release must be re-debounced and then produces one pulse.
- **Pulse overlap**: `key_valid` and `entry_valid` are coincident for E; otherwise `entry_valid` never asserts.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=2.
- **Reset**: assert `clr` mid-scan → `col`=1110, `value`=0, pulses 0. Release → `col` steps 1101, 1011, 0111, 1110 every 4 cycles.
- **Digit entry**: press 1, 2, 3, each held 3 scans and released 3 scans → three `key_valid` pulses, `value`=0x00000123, `digit_count`=3.
- **Overflow and backspace**: enter 9 digits 1..9 → `value`=0x12345678, count=8, 9th ignored. Press D → 0x01234567, count=7.
- **Enter**: with `value`=0x00000042, press E → `entry_valid` one cycle, `entry_value`=0x42, `value`=0, count=0. Press C on an empty buffer → no change, one `key_valid`.
- **Bounce and ghosting**:
  - Key 5 present for only 1 scan, then NONE → no pulse.
  - Keys 1 and 2 held together → result NONE, no pulse.
  - Key held 20 scans → exactly one pulse.
- **Reset during HELD**: hold 7, assert/deassert `clr` → one new pulse after 2 scans, `value`=0x7.
